pipeif_fetch: RTL and testbench
===============================

// Module: pipeif_fetch
// PURPOSE
//  IF stage of the 5-stage MIPS32 pipeline; consumes ID's pcsource/bpc/jpc/rpc and wpcir.
//  Owns the PC, drives a one-outstanding req/ack instruction-memory port, and holds a 1-entry skid buffer.
//  Loads the IF/ID register (dpc4, inst, dvalid) and honours the one-instruction branch delay slot.
// PARAMETERS
//  RESET_PC  32'h0000_0000  first fetch address after reset
//  NOP_INST  32'h0000_0000  instruction word inserted as a bubble (sll $0,$0,0)
// PORTS
//  clock       in   1   single clock; all state updates on posedge
//  reset       in   1   synchronous, active-high
//  pcsource    in   2   ID redirect select: 00 seq, 01 bpc, 10 rpc (jr), 11 jpc
//  bpc         in   32  branch target from ID
//  jpc         in   32  j/jal target from ID
//  rpc         in   32  jr target (forwarded rs) from ID
//  wpcir       in   1   ID may accept a new instruction (0 = load-use stall)
//  imem_req    out  1   fetch request; held with stable imem_addr until imem_ack
//  imem_addr   out  32  fetch address (= pc)
//  imem_ack    in   1   1-cycle pulse; imem_rdata valid in the same cycle
//  imem_rdata  in   32  fetched instruction word
//  dpc4        out  32  IF/ID: fetched pc + 4
//  inst        out  32  IF/ID: instruction (NOP_INST when bubble)
//  dvalid      out  1   IF/ID: inst is a real fetched instruction
// BEHAVIOUR
//  Reset (sync, high): pc<=RESET_PC; dpc4<=0; inst<=NOP_INST; dvalid<=0; buffer empty; redirect clear;
//   imem_req=0 while reset is high, 1 in the first cycle after. An in-flight request is abandoned;
//   memory must drop a transaction when imem_req falls, and imem_ack is only legal while imem_req=1.
//  FSM: REQ (imem_req=1, buf empty) / FULL (imem_req=0, buf holds one word).
//   REQ, ack, wpcir=1 -> word straight to IF/ID; stay REQ, pc advances.
//   REQ, ack, wpcir=0 -> word+pc4 into buffer; -> FULL, pc advances.
//   REQ, no ack       -> wpcir=1: IF/ID <= bubble (inst=NOP_INST, dvalid=0, dpc4 unchanged).
//   FULL, wpcir=1     -> buffer to IF/ID; -> REQ (request issued next cycle).
//   FULL, wpcir=0     -> hold everything.
//  IF/ID register changes only when wpcir=1; when wpcir=0 it holds, even if an ack arrives.
//  Sequential pc update on ack: pc <= pc + 4 (mod 2^32, wrap at 32'hFFFF_FFFC -> 0).
//  Redirect capture: when dvalid=1, wpcir=1 and pcsource!=00, target T is chosen:
//   bpc, jpc, or {rpc[31:2],2'b00}. The delay-slot fetch (branch pc+4) always completes and is delivered.
//   Delay slot in flight, no ack this cycle -> redir_pend<=1, redir_pc<=T; at its ack pc<=T and pend clears.
//   Delay-slot ack in same cycle as capture -> pc<=T directly.
//   Delay slot already in buffer (FULL)     -> pc<=T in the capture cycle (no request active).
//  pcsource is ignored when dvalid=0 or wpcir=0; ID re-presents it once the stall clears.
//  imem_addr never changes while imem_req=1 and no ack; imem_addr[1:0] is always 2'b00.
//  Latency: ack -> IF/ID valid on the next posedge (with wpcir=1); zero-wait memory gives 1 inst/cycle.
// STRUCTURE
//  pipe_defs.vh (shared with pipeid/pipecu): PCSRC_SEQ/BR/JR/J codes, NOP_INST, RESET_PC default.
//  Sub-module pipeif_pcsel: combinational 4:1 target mux (pcsource -> T, rpc alignment).
//  Top: pc register, redirect register, 2-state FSM, skid buffer, IF/ID register.
// TESTING
//  1 zero-wait memory, reset release -> addr 0,4,8..; dvalid=1 from cycle 2; dpc4 = addr+4.
//  2 ack delay 3 cycles, wpcir=1 -> 3 bubbles (dvalid=0, inst=0) between instructions; addr stable.
//  3 wpcir=0 for 2 cycles while ack arrives -> FULL, imem_req=0, IF/ID held; word delivered on wpcir=1.
//  4 beq at 0x10 taken (pcsource=01, bpc=0x40), delay slot in flight -> 0x14 delivered, next addr 0x40.
//  5 jr with rpc=0x103, delay slot in buffer -> pc=0x100 in capture cycle; after slot, fetch 0x100.
//  6 reset asserted mid-request at addr 0x20 -> imem_req=0 for that cycle; then fetch RESET_PC, dvalid=0.

Source files
------------

// File: rtl/pipeif_fetch_pkg.sv
// Shared definitions for the MIPS32 pipeline IF stage: redirect codes, bubble word,
// reset vector, fetch FSM states and the skid-buffer entry layout.
package pipeif_fetch_pkg;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JR  = 2'b10;
  localparam logic [1:0] PCSRC_J   = 2'b11;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [0:0] {
    ST_REQ  = 1'b0,
    ST_FULL = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] inst;
  } skid_entry_t;

  // Force a jump-register target onto a word boundary.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/pipeif_fetch_pcsel.sv
// Redirect target mux: picks the branch, jump or (word-aligned) jump-register target
// that ID asks for.
module pipeif_fetch_pcsel
  import pipeif_fetch_pkg::*;
(
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  output logic [31:0] target
);

  // Sequential code never reaches the redirect path, so it shares the branch leg.
  always_comb begin
    target = bpc;
    case (pcsource)
      PCSRC_BR: target = bpc;
      PCSRC_JR: target = word_align(rpc);
      PCSRC_J:  target = jpc;
      default:  target = bpc;
    endcase
  end

endmodule

// File: rtl/pipeif_fetch.sv
// IF stage: PC, one-outstanding instruction-memory port, 1-entry skid buffer, IF/ID
// register and branch-delay-slot aware redirect handling.
module pipeif_fetch
  import pipeif_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INST = NOP_INST_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] jpc,
  input  logic [31:0] rpc,
  input  logic        wpcir,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] dpc4,
  output logic [31:0] inst,
  output logic        dvalid
);

  fetch_state_t state_r;
  logic [31:0]  pc_r;
  logic         redir_pend_r;
  logic [31:0]  redir_pc_r;
  skid_entry_t  skid_r;

  logic [31:0]  target_s;
  logic [31:0]  pc4_s;
  logic [31:0]  seq_next_s;
  logic         ack_s;
  logic         cap_s;

  pipeif_fetch_pcsel u_pcsel (
    .pcsource (pcsource),
    .bpc      (bpc),
    .jpc      (jpc),
    .rpc      (rpc),
    .target   (target_s)
  );

  // The request is gated by reset so an in-flight fetch is dropped in the reset cycle itself.
  assign imem_req  = (state_r == ST_REQ) && !reset;
  assign imem_addr = pc_r;

  assign pc4_s      = pc_r + 32'd4;
  assign seq_next_s = redir_pend_r ? redir_pc_r : pc4_s;
  assign ack_s      = imem_ack && (state_r == ST_REQ);
  assign cap_s      = dvalid && wpcir && (pcsource != PCSRC_SEQ);

  // Fetch FSM with PC, pending redirect, skid buffer and IF/ID register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_REQ;
      pc_r         <= RESET_PC;
      redir_pend_r <= 1'b0;
      redir_pc_r   <= 32'h0000_0000;
      skid_r       <= '0;
      dpc4         <= 32'h0000_0000;
      inst         <= NOP_INST;
      dvalid       <= 1'b0;
    end else begin
      case (state_r)
        ST_REQ: begin
          if (ack_s) begin
            // This ack completes the delay slot whenever a redirect is captured or pending.
            pc_r         <= cap_s ? target_s : seq_next_s;
            redir_pend_r <= 1'b0;
            if (wpcir) begin
              dpc4   <= pc4_s;
              inst   <= imem_rdata;
              dvalid <= 1'b1;
            end else begin
              skid_r.pc4  <= pc4_s;
              skid_r.inst <= imem_rdata;
              state_r     <= ST_FULL;
            end
          end else begin
            if (cap_s) begin
              redir_pend_r <= 1'b1;
              redir_pc_r   <= target_s;
            end
            if (wpcir) begin
              inst   <= NOP_INST;
              dvalid <= 1'b0;
            end
          end
        end
        ST_FULL: begin
          if (wpcir) begin
            dpc4    <= skid_r.pc4;
            inst    <= skid_r.inst;
            dvalid  <= 1'b1;
            state_r <= ST_REQ;
            // Delay slot already fetched: redirect takes effect immediately.
            if (cap_s) begin
              pc_r <= target_s;
            end
          end
        end
        default: begin
          state_r <= ST_REQ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pipeif_fetch.sv
// Directed bench for pipeif_fetch: a queue/map based model of the fetch rules checked
// every cycle, plus literal expectations on address sequences and IF/ID contents.
module tb_pipeif_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  pcsource;
  logic [31:0] bpc, jpc, rpc;
  logic        wpcir;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] dpc4, inst;
  logic        dvalid;

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  pipeif_fetch dut (
    .clock      (clock),
    .reset      (reset),
    .pcsource   (pcsource),
    .bpc        (bpc),
    .jpc        (jpc),
    .rpc        (rpc),
    .wpcir      (wpcir),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dpc4       (dpc4),
    .inst       (inst),
    .dvalid     (dvalid)
  );

  int vectors = 0;
  int miscompares = 0;

  // model state: expected fetch address, IF/ID, buffered words, redirects keyed by slot address
  logic [31:0] e_addr, e_dpc4, e_inst;
  logic        e_dvalid;
  logic        m_init;
  logic [63:0] e_q[$];
  logic [31:0] redir[logic [31:0]];
  logic [31:0] log_q[$];
  int          delay, wait_cnt;
  logic        arm, arm_stall;
  logic [1:0]  arm_src;
  logic [31:0] arm_slot;
  logic        prev_hold;
  logic [31:0] prev_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] logged(input int i);
    if (i < log_q.size()) return log_q[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] target_of(input logic [1:0] s);
    case (s)
      2'b01:   return bpc;
      2'b10:   return rpc - (rpc % 32'd4);
      2'b11:   return jpc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic step(input logic rst, input logic wp);
    logic        e_req, ack_now, cap;
    logic [31:0] t, nxt;
    @(negedge clock);
    reset    = rst;
    wpcir    = wp;
    pcsource = 2'b00;
    if (arm && m_init && !rst && e_dvalid && e_dpc4 == arm_slot) begin
      pcsource = arm_src;
      if (arm_stall) begin
        wpcir     = 1'b0;
        arm_stall = 1'b0;
      end else if (wpcir) begin
        arm = 1'b0;
      end
    end
    e_req    = !rst && (e_q.size() == 0);
    ack_now  = e_req && (wait_cnt >= delay);
    imem_ack = ack_now;
    #1;
    chk("imem_req", {31'd0, imem_req}, {31'd0, e_req});
    if (m_init) begin
      chk("imem_addr", imem_addr, e_addr);
      chk("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);
      chk("dpc4", dpc4, e_dpc4);
      chk("inst", inst, e_inst);
      chk("dvalid", {31'd0, dvalid}, {31'd0, e_dvalid});
      if (prev_hold) chk("addr_stable", imem_addr, prev_addr);
    end
    prev_hold = e_req && !ack_now;
    prev_addr = imem_addr;
    if (ack_now) log_q.push_back(imem_addr);
    wait_cnt = (ack_now || !e_req) ? 0 : wait_cnt + 1;
    if (rst) begin
      e_addr = 32'h0; e_dpc4 = 32'h0; e_inst = 32'h0; e_dvalid = 1'b0;
      e_q.delete(); redir.delete();
      m_init = 1'b1; prev_hold = 1'b0;
    end else begin
      nxt = e_addr;
      cap = e_dvalid && wpcir && (pcsource != 2'b00);
      t   = target_of(pcsource);
      if (ack_now) begin
        if (redir.exists(e_addr)) begin
          nxt = redir[e_addr];
          redir.delete(e_addr);
        end else begin
          nxt = e_addr + 32'd4;
        end
      end
      // the delay slot is the word at the branch's pc+4 (= dpc4 while the branch sits in IF/ID)
      if (cap) begin
        if (ack_now && e_addr == e_dpc4) nxt = t;
        else if (e_q.size() != 0) nxt = t;
        else redir[e_dpc4] = t;
      end
      if (wpcir) begin
        if (e_q.size() != 0) begin
          {e_dpc4, e_inst} = e_q.pop_front();
          e_dvalid = 1'b1;
        end else if (ack_now) begin
          e_dpc4 = e_addr + 32'd4; e_inst = mem_word(e_addr); e_dvalid = 1'b1;
        end else begin
          e_inst = 32'h0; e_dvalid = 1'b0;
        end
      end else if (ack_now) begin
        e_q.push_back({e_addr + 32'd4, mem_word(e_addr)});
      end
      e_addr = nxt;
    end
  endtask

  task automatic start(input int d);
    delay = d; wait_cnt = 0; arm = 1'b0; arm_stall = 1'b0;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    log_q.delete();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b1; wpcir = 1'b1; imem_ack = 1'b0; pcsource = 2'b00;
    bpc = 32'h0000_0040; jpc = 32'hFFFF_FFF8; rpc = 32'h0000_0103;
    e_addr = 32'h0; e_dpc4 = 32'h0; e_inst = 32'h0; e_dvalid = 1'b0;
    m_init = 1'b0; prev_hold = 1'b0; prev_addr = 32'h0;
    delay = 0; wait_cnt = 0; arm = 1'b0; arm_stall = 1'b0; arm_src = 2'b00; arm_slot = 32'h0;

    // zero-wait streaming from reset
    start(0);
    run(2);
    chk("p1_dvalid_c2", {31'd0, dvalid}, 32'd1);
    chk("p1_dpc4_c2", dpc4, 32'h0000_0004);
    chk("p1_inst_c2", inst, 32'hC0DE_0000);
    run(6);
    chk("p1_seq0", logged(0), 32'h0000_0000);
    chk("p1_seq3", logged(3), 32'h0000_000C);
    chk("p1_seq7", logged(7), 32'h0000_001C);

    // three-cycle ack delay: bubbles between instructions
    start(3);
    run(12);
    chk("p2_seq1", logged(1), 32'h0000_0004);
    chk("p2_seq2", logged(2), 32'h0000_0008);

    // load-use stall while an ack lands: word parked in the buffer
    start(0);
    run(3);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("p3_req_full", {31'd0, imem_req}, 32'd0);
    chk("p3_hold_dpc4", dpc4, 32'h0000_000C);
    run(2);
    chk("p3_deliver", dpc4, 32'h0000_0010);
    run(1);

    // taken beq at 0x10 -> 0x40 with delay slot in flight
    start(1);
    arm = 1'b1; arm_src = 2'b01; arm_slot = 32'h0000_0014;
    run(20);
    chk("p4_seq4", logged(4), 32'h0000_0010);
    chk("p4_seq5", logged(5), 32'h0000_0014);
    chk("p4_seq6", logged(6), 32'h0000_0040);

    // jr at 0x8 with rpc=0x103 while the delay slot sits in the buffer
    start(0);
    arm = 1'b1; arm_stall = 1'b1; arm_src = 2'b10; arm_slot = 32'h0000_000C;
    run(6);
    chk("p5_addr", imem_addr, 32'h0000_0100);
    chk("p5_slot_dpc4", dpc4, 32'h0000_0010);
    run(4);
    chk("p5_seq3", logged(3), 32'h0000_000C);
    chk("p5_seq4", logged(4), 32'h0000_0100);

    // reset in the middle of the request for 0x20
    start(2);
    for (int i = 0; i < 60; i++) begin
      step(1'b0, 1'b1);
      if (e_addr == 32'h0000_0020 && wait_cnt == 1) break;
    end
    step(1'b1, 1'b1);
    chk("p6_reached", imem_addr, 32'h0000_0020);
    chk("p6_req_reset", {31'd0, imem_req}, 32'd0);
    log_q.delete();
    step(1'b0, 1'b1);
    chk("p6_req_after", {31'd0, imem_req}, 32'd1);
    chk("p6_addr_after", imem_addr, 32'h0000_0000);
    chk("p6_dvalid_after", {31'd0, dvalid}, 32'd0);
    run(4);
    chk("p6_seq0", logged(0), 32'h0000_0000);

    // j at 0x0 to 0xFFFFFFF8, slot acked in the capture cycle, pc wraps to 0
    start(0);
    arm = 1'b1; arm_src = 2'b11; arm_slot = 32'h0000_0004;
    run(8);
    chk("p7_seq2", logged(2), 32'hFFFF_FFF8);
    chk("p7_seq3", logged(3), 32'hFFFF_FFFC);
    chk("p7_seq4", logged(4), 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
